// File: rtl/digit_scan_pkg.sv
// digit_scan_pkg
// Shared types and helpers for the multiplexed-display scan controller.
//   state_t       : scan FSM states (BLANK is only reachable with DIGIT_SCAN_BLANK_EN)
//   MAX_DIGITS    : widest display the controller supports
//   didx_t        : digit index wide enough for MAX_DIGITS
//   next_t        : result of next_set_bit (index + wrap flag)
//   next_set_bit  : next participating digit above idx, wrapping to the lowest one
package digit_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  localparam int MAX_DIGITS = 8;

  typedef logic [2:0] didx_t;

  typedef struct packed {
    didx_t idx;
    logic  wrap;
  } next_t;

  // Searches idx+1, idx+2, ... modulo MAX_DIGITS. Callers zero-extend the
  // mask, so the modulo-8 walk never lands on a non-existent digit. If no
  // other bit is set, the current index is returned and flagged as a wrap,
  // which makes a single-digit mask start a new frame every slot.
  function automatic next_t next_set_bit(input logic [MAX_DIGITS-1:0] mask,
                                         input didx_t idx);
    next_t r;
    didx_t j;
    logic  found;
    r.idx  = idx;
    r.wrap = 1'b1;
    found  = 1'b0;
    for (int i = 1; i < MAX_DIGITS; i++) begin
      j = idx + didx_t'(i);
      if (!found && mask[j]) begin
        found  = 1'b1;
        r.idx  = j;
        r.wrap = (j < idx);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/digit_scan_ctrl_dwell.sv
// scan_dwell_cnt
// Dwell counter for one display slot: counts 0..DWELL-1 while run is high,
// restarting at 0 after the last cycle of the slot.
//   clkd     in   scan clock
//   rst      in   asynchronous active-high reset
//   clear    in   force the count back to 0 (takes priority over run)
//   run      in   advance the count this cycle
//   cnt      out  current position within the slot
//   slot_end out  high during the last cycle of a running slot
module scan_dwell_cnt #(
  parameter int DWELL = 1000,
  localparam int CNT_W = $clog2(DWELL)
) (
  input  logic             clkd,
  input  logic             rst,
  input  logic             clear,
  input  logic             run,
  output logic [CNT_W-1:0] cnt,
  output logic             slot_end
);

  assign slot_end = run && (cnt == CNT_W'(DWELL - 1));

  always_ff @(posedge clkd or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= slot_end ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl
// Multiplexed seven-segment scan controller. Walks an active-low one-hot
// anode select across the digits enabled in digit_mask, holding each for
// DWELL clkd cycles, and reports the current digit index plus a pulse at the
// start of every scan frame.
//   clkd        in   scan clock
//   rst         in   asynchronous active-high reset
//   en          in   scan enable
//   digit_mask  in   bit i set = digit i takes part in the scan
//   digit_sel   out  anode select, active-low, at most one bit low
//   digit_idx   out  index of the digit owning the current slot
//   frame_start out  one-cycle pulse on the first cycle of a frame
// Optional feature: define DIGIT_SCAN_BLANK_EN to blank all anodes for the
// first BLANK_CYCLES of every slot (anti-ghosting guard).
module digit_scan_ctrl
  import digit_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL        = 1000,
  parameter int BLANK_CYCLES = 16,
  localparam int IDX_W       = $clog2(NUM_DIGITS),
  localparam int CNT_W       = $clog2(DWELL)
) (
  input  logic                  clkd,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NUM_DIGITS-1:0] digit_mask,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic [IDX_W-1:0]      digit_idx,
  output logic                  frame_start
);

  localparam logic [NUM_DIGITS-1:0] ONE = NUM_DIGITS'(1);

  state_t                  state_q, state_d;
  logic [NUM_DIGITS-1:0]   sel_d;
  logic [IDX_W-1:0]        idx_d;
  logic                    fs_d;
  logic                    mask_ok;
  logic [MAX_DIGITS-1:0]   mask_ext;
  didx_t                   search_from;
  next_t                   nxt;
  logic [CNT_W-1:0]        cnt;
  logic                    slot_end;
  logic                    cnt_clear;
  logic                    unused_bits;

  assign mask_ok   = en && (|digit_mask);
  assign cnt_clear = !mask_ok || (state_q == IDLE);

  // Searching upward from the top index lands on the lowest set bit, so one
  // search serves both the scan start from IDLE and the slot-end advance.
  always_comb begin
    mask_ext                 = '0;
    mask_ext[NUM_DIGITS-1:0] = digit_mask;
    search_from              = didx_t'(MAX_DIGITS - 1);
    if (state_q != IDLE) begin
      search_from            = '0;
      search_from[IDX_W-1:0] = digit_idx;
    end
  end

  assign nxt = next_set_bit(mask_ext, search_from);

  scan_dwell_cnt #(.DWELL(DWELL)) u_dwell (
    .clkd     (clkd),
    .rst      (rst),
    .clear    (cnt_clear),
    .run      (!cnt_clear),
    .cnt      (cnt),
    .slot_end (slot_end)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = digit_sel;
    idx_d   = digit_idx;
    fs_d    = 1'b0;
    if (!mask_ok) begin
      state_d = IDLE;
      sel_d   = '1;
    end else begin
      case (state_q)
        IDLE: begin
          idx_d = nxt.idx[IDX_W-1:0];
          fs_d  = 1'b1;
`ifdef DIGIT_SCAN_BLANK_EN
          state_d = BLANK;
          sel_d   = '1;
`else
          state_d = SHOW;
          sel_d   = ~(ONE << nxt.idx);
`endif
        end
        SHOW: begin
          if (slot_end) begin
            idx_d = nxt.idx[IDX_W-1:0];
            fs_d  = nxt.wrap;
`ifdef DIGIT_SCAN_BLANK_EN
            state_d = BLANK;
            sel_d   = '1;
`else
            sel_d   = ~(ONE << nxt.idx);
`endif
          end else if (!digit_mask[digit_idx]) begin
            // A digit dropped from the mask goes dark at once; since the
            // select is held otherwise, it stays dark until the slot ends.
            sel_d = '1;
          end
        end
`ifdef DIGIT_SCAN_BLANK_EN
        BLANK: begin
          if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
            state_d = SHOW;
            sel_d   = digit_mask[digit_idx] ? ~(ONE << digit_idx) : '1;
          end
        end
`endif
        default: begin
          state_d = IDLE;
          sel_d   = '1;
        end
      endcase
    end
  end

  always_ff @(posedge clkd or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      digit_sel   <= '1;
      digit_idx   <= '0;
      frame_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      digit_sel   <= sel_d;
      digit_idx   <= idx_d;
      frame_start <= fs_d;
    end
  end

`ifdef DIGIT_SCAN_BLANK_EN
  assign unused_bits = ^nxt.idx;
`else
  // Without blanking the slot position is only needed for slot_end.
  localparam int unused_blank_cycles = BLANK_CYCLES;
  assign unused_bits = ^{nxt.idx, cnt};
`endif

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl
// Directed self-checking bench for digit_scan_ctrl with four digits.
// Builds with or without DIGIT_SCAN_BLANK_EN; expected anode patterns account
// for the blanked cycles at the start of each slot when the macro is defined.
module tb_digit_scan_ctrl;

`ifdef DIGIT_SCAN_BLANK_EN
  localparam int DW = 8;
  localparam int BL = 2;
`else
  localparam int DW = 4;
  localparam int BL = 0;
`endif

  logic       clkd = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] digit_mask;
  logic [3:0] digit_sel;
  logic [1:0] digit_idx;
  logic       frame_start;

  int checks = 0;
  int errors = 0;

  digit_scan_ctrl #(
    .NUM_DIGITS   (4),
    .DWELL        (DW),
    .BLANK_CYCLES (2)
  ) dut (
    .clkd        (clkd),
    .rst         (rst),
    .en          (en),
    .digit_mask  (digit_mask),
    .digit_sel   (digit_sel),
    .digit_idx   (digit_idx),
    .frame_start (frame_start)
  );

  always #5 clkd = ~clkd;

  // Expected anode pattern for digit d at position c within its slot.
  function automatic logic [3:0] exp_sel(input int d, input int c);
    logic [3:0] one;
    one = 4'b0001;
    if (c < BL) return 4'b1111;
    return ~(one << d);
  endfunction

  task automatic test_reset();
    rst        = 1'b1;
    en         = 1'b0;
    digit_mask = 4'b0000;
    repeat (2) @(posedge clkd);
    #1;
    checks++;
    if (digit_sel !== 4'b1111) begin errors++; $display("[TB] FAIL reset_sel got %b want 1111", digit_sel); end
    checks++;
    if (digit_idx !== 2'd0) begin errors++; $display("[TB] FAIL reset_idx got %0d want 0", digit_idx); end
    checks++;
    if (frame_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_fs got %b want 0", frame_start); end
    rst = 1'b0;
    @(posedge clkd);
    #1;
    checks++;
    if (digit_sel !== 4'b1111) begin errors++; $display("[TB] FAIL idle_sel got %b want 1111", digit_sel); end
  endtask

  task automatic test_full_scan();
    int slot, cs, d;
    digit_mask = 4'b1111;
    en         = 1'b1;
    for (int c = 0; c < 5 * DW + 2; c++) begin
      @(posedge clkd);
      #1;
      slot = c / DW;
      cs   = c % DW;
      d    = slot % 4;
      checks++;
      if (digit_sel !== exp_sel(d, cs)) begin errors++; $display("[TB] FAIL full_sel cyc %0d got %b want %b", c, digit_sel, exp_sel(d, cs)); end
      checks++;
      if (digit_idx !== d[1:0]) begin errors++; $display("[TB] FAIL full_idx cyc %0d got %0d want %0d", c, digit_idx, d); end
      checks++;
      if (frame_start !== (cs == 0 && d == 0)) begin errors++; $display("[TB] FAIL full_fs cyc %0d got %b want %b", c, frame_start, (cs == 0 && d == 0)); end
    end
  endtask

  task automatic test_en_drop();
    int slot, cs, d;
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clkd);
      #1;
      checks++;
      if (digit_sel !== 4'b1111) begin errors++; $display("[TB] FAIL endrop_sel cyc %0d got %b want 1111", k, digit_sel); end
      checks++;
      if (digit_idx !== 2'd1) begin errors++; $display("[TB] FAIL endrop_idx_hold cyc %0d got %0d want 1", k, digit_idx); end
      checks++;
      if (frame_start !== 1'b0) begin errors++; $display("[TB] FAIL endrop_fs cyc %0d got %b want 0", k, frame_start); end
    end
    digit_mask = 4'b0110;
    en         = 1'b1;
    for (int c = 0; c < 2 * DW + 1; c++) begin
      @(posedge clkd);
      #1;
      slot = c / DW;
      cs   = c % DW;
      d    = (slot % 2 == 0) ? 1 : 2;
      checks++;
      if (digit_sel !== exp_sel(d, cs)) begin errors++; $display("[TB] FAIL restart_sel cyc %0d got %b want %b", c, digit_sel, exp_sel(d, cs)); end
      checks++;
      if (digit_idx !== d[1:0]) begin errors++; $display("[TB] FAIL restart_idx cyc %0d got %0d want %0d", c, digit_idx, d); end
      checks++;
      if (frame_start !== (cs == 0 && d == 1)) begin errors++; $display("[TB] FAIL restart_fs cyc %0d got %b want %b", c, frame_start, (cs == 0 && d == 1)); end
    end
    en = 1'b0;
    @(posedge clkd);
    #1;
    checks++;
    if (digit_sel !== 4'b1111) begin errors++; $display("[TB] FAIL endrop2_sel got %b want 1111", digit_sel); end
  endtask

  task automatic test_alternate();
    int slot, cs, d;
    digit_mask = 4'b1010;
    en         = 1'b1;
    for (int c = 0; c < 4 * DW; c++) begin
      @(posedge clkd);
      #1;
      slot = c / DW;
      cs   = c % DW;
      d    = (slot % 2 == 0) ? 1 : 3;
      checks++;
      if (digit_sel !== exp_sel(d, cs)) begin errors++; $display("[TB] FAIL alt_sel cyc %0d got %b want %b", c, digit_sel, exp_sel(d, cs)); end
      checks++;
      if (digit_idx !== d[1:0]) begin errors++; $display("[TB] FAIL alt_idx cyc %0d got %0d want %0d", c, digit_idx, d); end
      checks++;
      if (frame_start !== (cs == 0 && d == 1)) begin errors++; $display("[TB] FAIL alt_fs cyc %0d got %b want %b", c, frame_start, (cs == 0 && d == 1)); end
    end
    digit_mask = 4'b0000;
    @(posedge clkd);
    #1;
    checks++;
    if (digit_sel !== 4'b1111) begin errors++; $display("[TB] FAIL zeromask_sel got %b want 1111", digit_sel); end
    checks++;
    if (digit_idx !== 2'd3) begin errors++; $display("[TB] FAIL zeromask_idx got %0d want 3", digit_idx); end
    checks++;
    if (frame_start !== 1'b0) begin errors++; $display("[TB] FAIL zeromask_fs got %b want 0", frame_start); end
  endtask

  task automatic test_mask_clear();
    int slot, cs, d, cc;
    logic [3:0] want;
    logic       want_fs;
    cc         = 2 * DW + BL + 1;
    digit_mask = 4'b1111;
    for (int c = 0; c <= 4 * DW; c++) begin
      @(posedge clkd);
      #1;
      slot    = c / DW;
      cs      = c % DW;
      d       = slot % 4;
      want    = (slot == 2 && c > cc) ? 4'b1111 : exp_sel(d, cs);
      want_fs = (cs == 0) && (slot == 0 || slot == 4);
      checks++;
      if (digit_sel !== want) begin errors++; $display("[TB] FAIL clr_sel cyc %0d got %b want %b", c, digit_sel, want); end
      checks++;
      if (digit_idx !== d[1:0]) begin errors++; $display("[TB] FAIL clr_idx cyc %0d got %0d want %0d", c, digit_idx, d); end
      checks++;
      if (frame_start !== want_fs) begin errors++; $display("[TB] FAIL clr_fs cyc %0d got %b want %b", c, frame_start, want_fs); end
      if (c == cc) digit_mask = 4'b1011;
    end
  endtask

  task automatic test_single_bit();
    int cs;
    en = 1'b0;
    @(posedge clkd);
    #1;
    checks++;
    if (digit_sel !== 4'b1111) begin errors++; $display("[TB] FAIL single_idle_sel got %b want 1111", digit_sel); end
    digit_mask = 4'b0100;
    en         = 1'b1;
    for (int c = 0; c < 3 * DW; c++) begin
      @(posedge clkd);
      #1;
      cs = c % DW;
      checks++;
      if (digit_sel !== exp_sel(2, cs)) begin errors++; $display("[TB] FAIL single_sel cyc %0d got %b want %b", c, digit_sel, exp_sel(2, cs)); end
      checks++;
      if (digit_idx !== 2'd2) begin errors++; $display("[TB] FAIL single_idx cyc %0d got %0d want 2", c, digit_idx); end
      checks++;
      if (frame_start !== (cs == 0)) begin errors++; $display("[TB] FAIL single_fs cyc %0d got %b want %b", c, frame_start, (cs == 0)); end
    end
  endtask

  task automatic test_async_reset();
    int slot, cs, d;
    @(posedge clkd);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (digit_sel !== 4'b1111) begin errors++; $display("[TB] FAIL areset_sel got %b want 1111", digit_sel); end
    checks++;
    if (digit_idx !== 2'd0) begin errors++; $display("[TB] FAIL areset_idx got %0d want 0", digit_idx); end
    checks++;
    if (frame_start !== 1'b0) begin errors++; $display("[TB] FAIL areset_fs got %b want 0", frame_start); end
    digit_mask = 4'b1100;
    @(posedge clkd);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 2 * DW; c++) begin
      @(posedge clkd);
      #1;
      slot = c / DW;
      cs   = c % DW;
      d    = (slot == 0) ? 2 : 3;
      checks++;
      if (digit_sel !== exp_sel(d, cs)) begin errors++; $display("[TB] FAIL resume_sel cyc %0d got %b want %b", c, digit_sel, exp_sel(d, cs)); end
      checks++;
      if (digit_idx !== d[1:0]) begin errors++; $display("[TB] FAIL resume_idx cyc %0d got %0d want %0d", c, digit_idx, d); end
      checks++;
      if (frame_start !== (c == 0)) begin errors++; $display("[TB] FAIL resume_fs cyc %0d got %b want %b", c, frame_start, (c == 0)); end
    end
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_en_drop();
    test_alternate();
    test_mask_clear();
    test_single_bit();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
